cdb_arbiter: RTL and testbench

// - Round-robin arbiter sharing the single common data bus (CDB) among functional-unit result ports (ADD, MUL, LS).
// - Grants at most one completed result per cycle.
// - Registers the winner and broadcasts tag/ROB index/data to the reservation stations and reorder buffer for one cycle.
// - Sits between the FU result stages and the RS/ROB wakeup logic, downstream of instruction issue.

---
 rtl/cdb_arbiter_if.sv | 30 +++
 rtl/cdb_arbiter.sv | 142 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// Requester-to-CDB bundle: per-FU result handshake in, registered broadcast out.
// "master" is the functional-unit/consumer side, "slave" is the arbiter.
interface cdb_arbiter_if #(
  parameter int N_REQ  = 3,
  parameter int TAG_W  = 4,
  parameter int ROB_W  = 3,
  parameter int DATA_W = 32
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*TAG_W-1:0]  req_tag;
  logic [N_REQ*ROB_W-1:0]  req_rob;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;

  logic                    cdb_valid;
  logic [TAG_W-1:0]        cdb_tag;
  logic [ROB_W-1:0]        cdb_rob;
  logic [DATA_W-1:0]       cdb_data;
  logic [1:0]              cdb_src;

  modport master (
    output req_valid, req_tag, req_rob, req_data,
    input  req_ready, cdb_valid, cdb_tag, cdb_rob, cdb_data, cdb_src
  );

  modport slave (
    input  req_valid, req_tag, req_rob, req_data,
    output req_ready, cdb_valid, cdb_tag, cdb_rob, cdb_data, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus arbiter: one FU result granted per cycle, broadcast registered.
// Optional performance counters are enabled by defining CDB_ARB_PERF_CNT_EN.
module cdb_arbiter #(
  parameter int N_REQ    = 3,
  parameter int TAG_W    = 4,
  parameter int ROB_W    = 3,
  parameter int DATA_W   = 32,
  parameter int NULL_TAG = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic cdb_hold,
  cdb_arbiter_if.slave bus
`ifdef CDB_ARB_PERF_CNT_EN
  ,
  output logic [31:0] perf_grant_cnt,
  output logic [31:0] perf_conflict_cnt
`endif
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SRC_W = 2;
  localparam logic [TAG_W-1:0] NULL_VAL = TAG_W'(NULL_TAG);

  logic [TAG_W-1:0]  tag_arr  [N_REQ];
  logic [ROB_W-1:0]  rob_arr  [N_REQ];
  logic [DATA_W-1:0] data_arr [N_REQ];

  logic [PTR_W-1:0]  rr_ptr_reg;
  logic [PTR_W-1:0]  rr_ptr_next;
  logic [N_REQ-1:0]  upper_mask;
  logic [N_REQ-1:0]  pick;
  logic [PTR_W-1:0]  win_idx;
  logic              win_found;
  logic              grant_en;
  logic [N_REQ-1:0]  ready;

  logic              cdb_valid_reg;
  logic [TAG_W-1:0]  cdb_tag_reg;
  logic [ROB_W-1:0]  cdb_rob_reg;
  logic [DATA_W-1:0] cdb_data_reg;
  logic [SRC_W-1:0]  cdb_src_reg;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign tag_arr[gi]  = bus.req_tag[gi*TAG_W +: TAG_W];
      assign rob_arr[gi]  = bus.req_rob[gi*ROB_W +: ROB_W];
      assign data_arr[gi] = bus.req_data[gi*DATA_W +: DATA_W];
      assign ready[gi]    = grant_en && (win_idx == PTR_W'(gi));
    end
  endgenerate

  // Requesters at or above rr_ptr win first; if none of them is valid,
  // the scan wraps to the lowest valid index.
  always_comb begin
    upper_mask = '0;
    for (int i = 0; i < N_REQ; i++) begin
      upper_mask[i] = (PTR_W'(i) >= rr_ptr_reg);
    end
    pick = ((bus.req_valid & upper_mask) != '0) ? (bus.req_valid & upper_mask)
                                                 : bus.req_valid;
    win_idx   = '0;
    win_found = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (pick[i]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(i);
      end
    end
  end

  assign grant_en    = win_found && !flush && !cdb_hold && !rst;
  assign rr_ptr_next = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
  assign bus.req_ready = ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg    <= '0;
      cdb_valid_reg <= 1'b0;
      cdb_tag_reg   <= NULL_VAL;
      cdb_rob_reg   <= '0;
      cdb_data_reg  <= '0;
      cdb_src_reg   <= '0;
    end else begin
      if (flush) begin
        rr_ptr_reg <= '0;
      end else if (grant_en) begin
        rr_ptr_reg <= rr_ptr_next;
      end

      if (grant_en) begin
        // A null-tag result is consumed but never announced to consumers.
        cdb_valid_reg <= (tag_arr[win_idx] != NULL_VAL);
        cdb_tag_reg   <= tag_arr[win_idx];
        cdb_rob_reg   <= rob_arr[win_idx];
        cdb_data_reg  <= data_arr[win_idx];
        cdb_src_reg   <= SRC_W'(win_idx);
      end else begin
        cdb_valid_reg <= 1'b0;
        cdb_tag_reg   <= NULL_VAL;
      end
    end
  end

  assign bus.cdb_valid = cdb_valid_reg;
  assign bus.cdb_tag   = cdb_tag_reg;
  assign bus.cdb_rob   = cdb_rob_reg;
  assign bus.cdb_data  = cdb_data_reg;
  assign bus.cdb_src   = cdb_src_reg;

`ifdef CDB_ARB_PERF_CNT_EN
  localparam int CNT_W = $clog2(N_REQ + 1);

  logic [CNT_W-1:0] valid_cnt;
  logic [31:0]      grant_cnt_reg;
  logic [31:0]      conflict_cnt_reg;

  always_comb begin
    valid_cnt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      valid_cnt = valid_cnt + CNT_W'(bus.req_valid[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt_reg    <= '0;
      conflict_cnt_reg <= '0;
    end else begin
      if (grant_en) begin
        grant_cnt_reg <= grant_cnt_reg + 32'd1;
      end
      if (!flush && !cdb_hold && (valid_cnt >= CNT_W'(2))) begin
        conflict_cnt_reg <= conflict_cnt_reg + 32'd1;
      end
    end
  end

  assign perf_grant_cnt    = grant_cnt_reg;
  assign perf_conflict_cnt = conflict_cnt_reg;
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: grants checked combinationally, broadcasts via a scoreboard queue.
module tb_cdb_arbiter;
  localparam int N_REQ  = 3;
  localparam int TAG_W  = 4;
  localparam int ROB_W  = 3;
  localparam int DATA_W = 32;
  localparam logic [TAG_W-1:0] NULL_T = 4'd12;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [ROB_W-1:0]  rob;
    logic [DATA_W-1:0] data;
    logic [1:0]        src;
  } bc_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic cdb_hold = 1'b0;

  logic [TAG_W-1:0]  tag_m  [N_REQ];
  logic [ROB_W-1:0]  rob_m  [N_REQ];
  logic [DATA_W-1:0] data_m [N_REQ];

  bc_t exp_q[$];
  int  total = 0;
  int  bad = 0;

  always #5 clk = ~clk;

  cdb_arbiter_if #(.N_REQ(N_REQ), .TAG_W(TAG_W), .ROB_W(ROB_W), .DATA_W(DATA_W)) bus ();

`ifdef CDB_ARB_PERF_CNT_EN
  logic [31:0] perf_grant_cnt;
  logic [31:0] perf_conflict_cnt;
`endif

  cdb_arbiter #(
    .N_REQ(N_REQ), .TAG_W(TAG_W), .ROB_W(ROB_W), .DATA_W(DATA_W), .NULL_TAG(12)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .cdb_hold (cdb_hold),
    .bus      (bus)
`ifdef CDB_ARB_PERF_CNT_EN
    ,
    .perf_grant_cnt    (perf_grant_cnt),
    .perf_conflict_cnt (perf_conflict_cnt)
`endif
  );

  assign bus.req_tag  = {tag_m[2], tag_m[1], tag_m[0]};
  assign bus.req_rob  = {rob_m[2], rob_m[1], rob_m[0]};
  assign bus.req_data = {data_m[2], data_m[1], data_m[0]};

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic check_out(input string name);
    bc_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({name, ".cdb_valid"}, 64'(bus.cdb_valid), 64'(1'b1));
      chk({name, ".cdb_tag"},   64'(bus.cdb_tag),   64'(e.tag));
      chk({name, ".cdb_rob"},   64'(bus.cdb_rob),   64'(e.rob));
      chk({name, ".cdb_data"},  64'(bus.cdb_data),  64'(e.data));
      chk({name, ".cdb_src"},   64'(bus.cdb_src),   64'(e.src));
    end else begin
      chk({name, ".cdb_valid"}, 64'(bus.cdb_valid), 64'(1'b0));
      chk({name, ".cdb_tag"},   64'(bus.cdb_tag),   64'(NULL_T));
    end
  endtask

  // One cycle: present valids, check the grant, then check the broadcast it produced.
  task automatic drive(input logic [2:0] v, input logic [2:0] exp_ready, input string name);
    bus.req_valid = v;
    #1;
    chk({name, ".req_ready"}, 64'(bus.req_ready), 64'(exp_ready));
    for (int i = 0; i < N_REQ; i++) begin
      if (exp_ready[i] && (tag_m[i] != NULL_T)) begin
        exp_q.push_back('{tag_m[i], rob_m[i], data_m[i], 2'(i)});
      end
    end
    @(posedge clk);
    #1;
    check_out(name);
    for (int i = 0; i < N_REQ; i++) begin
      if (exp_ready[i]) data_m[i] = $urandom;
    end
    $display("step %s valid=%b ready=%b cdb_valid=%b tag=%0d src=%0d",
             name, v, bus.req_ready, bus.cdb_valid, bus.cdb_tag, bus.cdb_src);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, ".cdb_valid"}, 64'(bus.cdb_valid), 64'(1'b0));
    chk({name, ".cdb_tag"},   64'(bus.cdb_tag),   64'(NULL_T));
    chk({name, ".cdb_rob"},   64'(bus.cdb_rob),   64'd0);
    chk({name, ".cdb_data"},  64'(bus.cdb_data),  64'd0);
    chk({name, ".cdb_src"},   64'(bus.cdb_src),   64'd0);
  endtask

  initial begin
    for (int i = 0; i < N_REQ; i++) begin
      tag_m[i]  = 4'(i + 1);
      rob_m[i]  = 3'(i);
      data_m[i] = 32'hA000_0000 + 32'(i);
    end
    bus.req_valid = '0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    chk("reset.req_ready", 64'(bus.req_ready), 64'd0);
    rst = 1'b0;

    // Single request from MUL
    tag_m[1] = 4'd10; rob_m[1] = 3'd5; data_m[1] = 32'h1234;
    drive(3'b010, 3'b010, "single");
    drive(3'b000, 3'b000, "idle");
    chk("idle.rob_hold",  64'(bus.cdb_rob),  64'd5);
    chk("idle.data_hold", 64'(bus.cdb_data), 64'h1234);
    chk("idle.src_hold",  64'(bus.cdb_src),  64'd1);

    // All three valid from reset: order 0,1,2,0,1,2
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tag_m[0] = 4'd1; tag_m[1] = 4'd2; tag_m[2] = 4'd3;
    for (int k = 0; k < 6; k++) begin
      drive(3'b111, 3'(3'b001 << (k % 3)), "rr");
    end

    // Hold for three cycles
    cdb_hold = 1'b1;
    repeat (3) drive(3'b001, 3'b000, "hold");
    cdb_hold = 1'b0;
    drive(3'b001, 3'b001, "hold_rel");

    // Null tag from LS, then pointer must be back at 0
    tag_m[2] = NULL_T;
    drive(3'b100, 3'b100, "null");
    tag_m[2] = 4'd3;
    drive(3'b111, 3'b001, "null_ptr");

    // Grant leaves rr_ptr at 2, flush (with hold) next cycle
    drive(3'b010, 3'b010, "pre_flush");
    flush = 1'b1;
    cdb_hold = 1'b1;
    chk("flush.bcast_kept", 64'(bus.cdb_valid), 64'd1);
    drive(3'b111, 3'b000, "flush");
    flush = 1'b0;
    cdb_hold = 1'b0;
    drive(3'b110, 3'b010, "post_flush");

    // Reset while a broadcast is live
    drive(3'b001, 3'b001, "pre_rst");
    rst = 1'b1;
    bus.req_valid = 3'b111;
    @(posedge clk);
    #1;
    check_reset_outputs("mid_rst");
    exp_q.delete();
    rst = 1'b0;

    // 4 grants, 2 counted conflict cycles (the held one does not count)
    cdb_hold = 1'b1;
    drive(3'b011, 3'b000, "perf_hold");
    cdb_hold = 1'b0;
    drive(3'b011, 3'b001, "perf1");
    drive(3'b010, 3'b010, "perf2");
    drive(3'b101, 3'b100, "perf3");
    drive(3'b001, 3'b001, "perf4");
    drive(3'b000, 3'b000, "end");
`ifdef CDB_ARB_PERF_CNT_EN
    chk("perf.grant_cnt",    64'(perf_grant_cnt),    64'd4);
    chk("perf.conflict_cnt", 64'(perf_conflict_cnt), 64'd2);
`endif
    chk("end.queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
